// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: shared constants, FSM states and nibble-count helper
package nibble_serial_adder_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction
endpackage

// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: operand/result valid-ready bus for the serial adder
interface nibble_serial_adder_if #(parameter int WIDTH = 16) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  modport master (output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum, cout, ovf);
  modport slave (input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/nibble_serial_adder_cla4_cin.sv
// cla4_cin: 4-bit carry-lookahead slice with carry-in, exposing every bit carry
module cla4_cin (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_ci,
  output logic [3:0] o_s,
  output logic [3:0] o_c
);
  logic [3:0] w_g, w_p;
  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;
  assign o_c[0] = w_g[0] | (w_p[0] & i_ci);
  assign o_c[1] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_ci);
  assign o_c[2] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0]) | (w_p[2] & w_p[1] & w_p[0] & i_ci);
  assign o_c[3] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1]) | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_ci);
  assign o_s = w_p ^ {o_c[2:0], i_ci};
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit a+b+cin computed one nibble per clock through one CLA slice
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(parameter int WIDTH = 16) (
  input logic clk,
  input logic rst,
  nibble_serial_adder_if.slave bus
);
  localparam int NIB = nib_count(WIDTH);
  localparam int CW = $clog2(NIB);
  state_t r_state;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic [CW-1:0] r_cnt;
  logic r_c, r_cout, r_ovf, r_in_ready, r_out_valid;
  logic [NIBBLE_W-1:0] w_s, w_c;
  logic [1:0] w_unused;
  assign w_unused = w_c[1:0];
  cla4_cin u_cla (
    .i_a (r_a[NIBBLE_W-1:0]),
    .i_b (r_b[NIBBLE_W-1:0]),
    .i_ci(r_c),
    .o_s (w_s),
    .o_c (w_c)
  );
  // sum nibbles enter at the top so the LSB nibble lands at bit 0 after NIB shifts
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_a <= '0;
      r_b <= '0;
      r_sum <= '0;
      r_cnt <= '0;
      r_c <= 1'b0;
      r_cout <= 1'b0;
      r_ovf <= 1'b0;
      r_in_ready <= 1'b1;
      r_out_valid <= 1'b0;
    end else
      case (r_state)
        IDLE: if (bus.in_valid && r_in_ready) begin
          r_a <= bus.a;
          r_b <= bus.b;
          r_c <= bus.cin;
          r_cnt <= '0;
          r_in_ready <= 1'b0;
          r_state <= RUN;
        end
        RUN: begin
          r_sum <= {w_s, r_sum[WIDTH-1:NIBBLE_W]};
          r_a <= r_a >> NIBBLE_W;
          r_b <= r_b >> NIBBLE_W;
          r_c <= w_c[3];
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(NIB - 1)) begin
            r_cout <= w_c[3];
            r_ovf <= w_c[3] ^ w_c[2];
            r_out_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
  assign bus.in_ready = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf = r_ovf;
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Adds two WIDTH-bit operands plus a carry-in, 4 bits per clock, through one 4-bit carry-lookahead slice.
- The nibble carry-out is registered and chained into the next nibble.
- Sits directly upstream of the 4-bit CLA datapath: it slices wide operands into nibbles, feeds the slice, and reassembles the sum.
- Trades latency for area in the wide-add path. Valid/ready handshake on both sides.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 8.
- NIB (derived), WIDTH/4, number of nibble cycles per add.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands a, b, cin valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  sum, cout, ovf valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
  - Nibble counter, carry register and operand shift registers are cleared.
- Reset wins over every other event in the same cycle, including an in-flight operation. That operation is discarded and no result is produced.
- States IDLE, RUN, DONE:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, capture a, b into shift registers and cin into the carry register, clear the counter, go to RUN. Otherwise stay.
  - RUN: in_ready=0, out_valid=0. Each cycle:
    - slice inputs are the low nibbles of the shift registers plus the carry register;
    - the slice sum nibble shifts into the top of the sum register (LSB nibble first);
    - the operand registers shift right by 4;
    - the carry register takes the slice carry-out;
    - the counter increments.
  - RUN, last nibble (counter==NIB-1): additionally latch cout = slice carry[3] and ovf = slice carry[3] XOR slice carry[2], then go to DONE.
  - DONE: out_valid=1, in_ready=0. sum, cout and ovf are held stable while out_ready=0. On out_ready=1, go to IDLE at that edge; out_valid drops the next cycle.
- Latency:
  - Accept at edge T; out_valid is high from edge T+NIB. NIB=4 cycles for WIDTH=16.
  - Minimum interval between accepts: NIB+2 cycles.
  - No overlap: a new operation is never accepted while RUN or DONE.
- Outputs:
  - In IDLE after a completed transfer, sum, cout and ovf retain the last result; they are don't-care when out_valid=0.
  - sum, cout and ovf are registered; no combinational path from a or b to any output.
- in_valid is ignored while in_ready=0. Inputs a, b and cin need only be stable in the accept cycle.
- Counter width is clog2(NIB). Wrap from NIB-1 to 0 is never observed, because the state leaves RUN.
- Arithmetic: {cout,sum} = a + b + cin exactly; the carry ripples across nibble boundaries through the carry register only.

Decomposition:
- Shared package:
  - NIBBLE_W=4;
  - the state enum {IDLE, RUN, DONE};
  - a function that computes the derived NIB from WIDTH.
- One sub-module, cla4_cin: a 4-bit carry-lookahead slice with carry-in.
  - Inputs a[3:0], b[3:0], ci. Outputs s[3:0], c[3:0].
  - Generate/propagate lookahead: c[0]=g0|p0&ci, and so on through c[3].
  - Instantiated once; all sequencing lives in the top module.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0, out_ready=1 → sum=0x5555, cout=0, ovf=0; out_valid rises exactly 4 cycles after accept and lasts 1 cycle.
- a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1, ovf=0 (carry ripples through all 4 nibble registers).
- a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 → sum=0x0000, cout=1, ovf=1.
- a=0x00FF, b=0x0001, out_ready held 0 for 3 cycles in DONE → out_valid=1 and sum=0x0100 stable all 3 cycles; in_ready=0 and an in_valid pulse is ignored; transfer completes when out_ready=1, then in_ready=1.
- rst asserted on the 2nd RUN cycle of a=0xAAAA, b=0x5555 → next cycle IDLE, out_valid=0, sum=0, cout=0; no result ever emitted. A following add of 0x0001+0x0001 gives 0x0002.
- Back-to-back ops with in_valid held high and out_ready=1 → accepts exactly 6 cycles apart; results in order. Random a/b/cin over 1000 ops match the {cout,sum} and ovf reference model.
